fpu_cvt_to_float: RTL and testbench

//  Multi-cycle integer-to-single-precision converter for FCVT.S.W / FCVT.S.WU.
//  It is the inverse of the FPU float-to-int path. Operands come from the integer

---
 rtl/fpu_cvt_to_float.sv | 169 ++++++++++++++++
 tb/tb_fpu_cvt_to_float.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_float.sv
// Multi-cycle integer-to-single-precision converter (FCVT.S.W / FCVT.S.WU).
// Normalisation shifts the magnitude iteratively, then a single rounding step
// packs the IEEE-754 result and the inexact flag.
module fpu_cvt_to_float #(
  parameter int unsigned NORM_STEP = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_unsigned_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic [31:0] int_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] float_o,
  output logic        inexact_o
);

  localparam int unsigned INT_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned RM_W   = 3;

  // Exponent of an unshifted 32-bit magnitude; it only decreases during
  // normalisation and rises by at most one on a rounding carry, so it stays
  // within 127..159 and eight bits hold it exactly.
  localparam logic [EXP_W-1:0] EXP_START = EXP_W'(158);

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [RM_W-1:0]   rm_q, rm_d;
  logic [INT_W-1:0]  float_d;
  logic              inexact_d;

  // Rounding datapath signals
  logic [MANT_W-1:0] mant;
  logic              lsb_bit;
  logic              guard_bit;
  logic              sticky_bit;
  logic              round_up;
  logic [MANT_W:0]   m25;
  logic [EXP_W-1:0]  exp_rnd;
  logic [FRAC_W-1:0] frac;
  logic              in_sign;
  logic [INT_W-1:0]  in_mag;

  // Operand sign and magnitude; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    in_sign = ~is_unsigned_i & int_i[INT_W-1];
    in_mag  = in_sign ? INT_W'(~int_i + INT_W'(1)) : int_i;
  end

  // Round the normalised magnitude and pack the result fields
  always_comb begin
    mant       = mag_q[INT_W-1 -: MANT_W];
    lsb_bit    = mag_q[8];
    guard_bit  = mag_q[7];
    sticky_bit = |mag_q[6:0];
    case (rm_q)
      RM_RNE:  round_up = guard_bit & (lsb_bit | sticky_bit);
      RM_RDN:  round_up = sign_q & (guard_bit | sticky_bit);
      RM_RUP:  round_up = ~sign_q & (guard_bit | sticky_bit);
      RM_RMM:  round_up = guard_bit;
      default: round_up = 1'b0;
    endcase
    m25 = {1'b0, mant} + (MANT_W+1)'(round_up);
    // On carry m25 is exactly 1<<24, so its upper slice is the all-zero fraction
    if (m25[MANT_W]) begin
      exp_rnd = exp_q + EXP_W'(1);
      frac    = m25[MANT_W-1:1];
    end else begin
      exp_rnd = exp_q;
      frac    = m25[FRAC_W-1:0];
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    rm_d      = rm_q;
    float_d   = float_o;
    inexact_d = inexact_o;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sign_d = in_sign;
          rm_d   = rounding_mode_i;
          mag_d  = in_mag;
          exp_d  = EXP_START;
          if (in_mag == '0) begin
            // Zero always converts to +0 and is exact
            float_d   = '0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[INT_W-1]) begin
          state_d = ROUND;
        end else if (mag_q[INT_W-1 -: NORM_STEP] == '0) begin
          mag_d = mag_q << NORM_STEP;
          exp_d = exp_q - EXP_W'(NORM_STEP);
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        float_d   = {sign_q, exp_rnd, frac};
        inexact_d = guard_bit | sticky_bit;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      rm_q      <= '0;
      float_o   <= '0;
      inexact_o <= 1'b0;
      valid_o   <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      rm_q      <= rm_d;
      float_o   <= float_d;
      inexact_o <= inexact_d;
      valid_o   <= (state_d == DONE);
      ready_o   <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_fpu_cvt_to_float.sv
// Bench for fpu_cvt_to_float: directed corner cases plus randomized operands,
// checked against an arithmetic reference model for two NORM_STEP settings.
module tb_fpu_cvt_to_float;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        uns;
  logic [2:0]  rm;
  logic [31:0] iv;

  logic        r1, v1, x1;
  logic [31:0] f1;
  logic        r8, v8, x8;
  logic [31:0] f8;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpu_cvt_to_float #(.NORM_STEP(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .is_unsigned_i(uns),
    .rounding_mode_i(rm), .int_i(iv),
    .ready_o(r1), .valid_o(v1), .float_o(f1), .inexact_o(x1)
  );

  fpu_cvt_to_float #(.NORM_STEP(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .is_unsigned_i(uns),
    .rounding_mode_i(rm), .int_i(iv),
    .ready_o(r8), .valid_o(v8), .float_o(f8), .inexact_o(x8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference conversion: exact value scaled to 24 significant bits, with the
  // discarded remainder compared against half an ulp.
  function automatic void ref_cvt(input logic u, input logic [2:0] m, input logic [31:0] v,
                                  output logic [31:0] f, output logic nx);
    logic            s;
    logic [31:0]     mag;
    int              p;
    int              drop;
    int              e;
    longint unsigned q;
    longint unsigned rem;
    longint unsigned half;
    logic            up;
    s   = !u && v[31];
    mag = s ? (~v + 32'd1) : v;
    f   = 32'h0;
    nx  = 1'b0;
    if (mag == 32'h0) return;
    p = 31;
    while (!mag[p]) p--;
    e = 127 + p;
    if (p <= 23) begin
      q    = 64'(mag) << (23 - p);
      rem  = 0;
      half = 0;
    end else begin
      drop = p - 23;
      q    = 64'(mag) >> drop;
      rem  = 64'(mag) & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
    end
    nx = (rem != 0);
    case (m)
      3'd0:    up = nx && (rem > half || (rem == half && q[0]));
      3'd2:    up = s && nx;
      3'd3:    up = !s && nx;
      3'd4:    up = nx && (rem >= half);
      default: up = 1'b0;
    endcase
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    f = {s, 8'(e), 23'(q)};
  endfunction

  // Expected valid latency in edges, counting the accepting edge
  function automatic int lat_of(input int step, input logic u, input logic [31:0] v);
    logic [31:0] m;
    int          k;
    m = (!u && v[31]) ? (~v + 32'd1) : v;
    k = 0;
    if (m == 32'h0) return 1;
    while (!m[31]) begin
      if ((m >> (32 - step)) == 32'h0) m = m << step;
      else m = m << 1;
      k++;
    end
    return k + 3;
  endfunction

  task automatic convert(input logic u, input logic [2:0] m, input logic [31:0] v, input bit poke);
    logic [31:0] ef;
    logic        enx;
    int          el1, el8;
    int          l1, l8, edges;
    logic [31:0] cf1, cf8;
    logic        cx1, cx8;
    ref_cvt(u, m, v, ef, enx);
    el1 = lat_of(1, u, v);
    el8 = lat_of(8, u, v);
    l1 = 0; l8 = 0; edges = 0;
    cf1 = 'x; cf8 = 'x; cx1 = 1'bx; cx8 = 1'bx;
    @(negedge clk);
    start = 1'b1; uns = u; rm = m; iv = v;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        check("busy_ready", 32'(r1), 32'd0);
      end
      if (poke && v != 32'h0 && edges == 2) begin
        start = 1'b1; iv = $urandom; rm = 3'($urandom); uns = ~u;
      end
      if (edges == 3) start = 1'b0;
      if (v1 && l1 == 0) begin l1 = edges; cf1 = f1; cx1 = x1; end
      if (v8 && l8 == 0) begin l8 = edges; cf8 = f8; cx8 = x8; end
      if (l1 != 0 && edges == l1 + 1) begin
        check("valid_pulse", 32'(v1), 32'd0);
        check("ready_back", 32'(r1), 32'd1);
      end
      if ((l1 != 0 && l8 != 0 && edges > l1 && edges > l8) || edges >= 60) break;
    end
    check("float_s1", cf1, ef);
    check("nx_s1", 32'(cx1), 32'(enx));
    check("lat_s1", 32'(l1), 32'(el1));
    check("float_s8", cf8, ef);
    check("nx_s8", 32'(cx8), 32'(enx));
    check("lat_s8", 32'(l8), 32'(el8));
    check("float_held", f1, ef);
  endtask

  initial begin
    int vcount;
    logic [31:0] rv;
    reset = 1'b1; start = 1'b0; uns = 1'b0; rm = 3'd0; iv = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_float", f1, 32'h0);
    check("rst_nx", 32'(x1), 32'd0);
    check("rst_valid", 32'(v1), 32'd0);
    check("rst_ready", 32'(r1), 32'd1);
    reset = 1'b0;

    // Directed corner cases
    convert(1'b0, 3'd0, 32'h0000_0001, 1'b0);
    check("one_exact", f1, 32'h3F80_0000);
    convert(1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0);
    check("minus_one", f1, 32'hBF80_0000);
    convert(1'b0, 3'd0, 32'h8000_0000, 1'b0);
    check("int_min", f1, 32'hCF00_0000);
    convert(1'b0, 3'd0, 32'h7FFF_FFFF, 1'b0);
    check("max_rne", f1, 32'h4F00_0000);
    convert(1'b0, 3'd1, 32'h7FFF_FFFF, 1'b0);
    check("max_rtz", f1, 32'h4EFF_FFFF);
    convert(1'b0, 3'd2, 32'h7FFF_FFFF, 1'b0);
    check("max_rdn", f1, 32'h4EFF_FFFF);
    convert(1'b0, 3'd3, 32'h7FFF_FFFF, 1'b0);
    check("max_rup", f1, 32'h4F00_0000);
    convert(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    check("wu_carry", f1, 32'h4F80_0000);
    convert(1'b1, 3'd0, 32'h8000_0000, 1'b0);
    check("wu_msb", f1, 32'h4F00_0000);
    convert(1'b0, 3'd0, 32'h0100_0001, 1'b0);
    check("tie_even", f1, 32'h4B80_0000);
    convert(1'b0, 3'd4, 32'h0100_0001, 1'b0);
    check("tie_rmm", f1, 32'h4B80_0001);
    convert(1'b0, 3'd3, 32'h0100_0001, 1'b0);
    check("tie_rup", f1, 32'h4B80_0001);
    convert(1'b0, 3'd6, 32'h7FFF_FFFF, 1'b0);
    check("rm_illegal", f1, 32'h4EFF_FFFF);
    convert(1'b0, 3'd3, 32'h0000_0000, 1'b0);
    convert(1'b0, 3'd2, 32'hF123_4567, 1'b1);

    // Reset in the middle of normalisation
    @(negedge clk);
    start = 1'b1; uns = 1'b0; rm = 3'd0; iv = 32'h0000_0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("midrst_float", f1, 32'h0);
    check("midrst_nx", 32'(x1), 32'd0);
    check("midrst_valid", 32'(v1), 32'd0);
    check("midrst_ready", 32'(r1), 32'd1);
    check("midrst_ready8", 32'(r8), 32'd1);
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (v1 || v8) vcount++;
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);
    convert(1'b0, 3'd0, 32'h0000_0300, 1'b0);

    // Randomized operands across magnitudes and modes
    for (int i = 0; i < 60; i++) begin
      rv = $urandom;
      rv = rv >> $urandom_range(0, 31);
      convert(1'($urandom), 3'($urandom_range(0, 7)), rv, (i % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
